i2c_master_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one I2C master FSM among NREQ requesters.
- Captures a winning request and launches it on the master.
- Steers write bytes from the granted requester to the master and read bytes back to it.
- Returns a completion status to the owner.
- Sits between client blocks (sensor pollers, config loaders) and the I2C master; runs on the system clock.

---
 rtl/i2c_arb_pkg.sv | 30 +++
 rtl/i2c_master_arbiter_rr.sv | 36 +++
 rtl/i2c_master_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the I2C master arbiter.
// Optional watchdog enabled by I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;

  localparam int ADDR_W  = 7;
  localparam int NBYTE_W = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_BUSY = 3'd3,
    RUN       = 3'd4,
    RESP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK      = 2'd0,
    RESP_NACK    = 2'd1,
    RESP_TIMEOUT = 2'd2
  } resp_e;

  function automatic logic [NBYTE_W-1:0] fix_nbyte(
    input logic [NBYTE_W-1:0] n
  );
    return (n == '0) ? NBYTE_W'(1) : n;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_rr.sv
// Combinational round-robin pick: first set req bit at or
// above ptr, wrapping, as one-hot plus binary index.
module rr_arbiter_core #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt_oh,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IW:0]     sum;

  // rot[k] is requester (ptr+k) mod NREQ
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IW+1)'(k);
      end
    end
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx    = sum[IW-1:0];
    gnt_oh = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C master among NREQ clients.
// Define I2C_ARB_TIMEOUT_EN to add the transaction watchdog.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [NREQ-1:0]           req,
  input  logic [ADDR_W*NREQ-1:0]    req_addr,
  input  logic [NREQ-1:0]           req_rw,
  input  logic [NBYTE_W*NREQ-1:0]   req_nbyte,
  input  logic [DATA_W*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           wdata_ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [NREQ-1:0]           rdata_valid,
  output logic [NREQ-1:0]           done,
  output logic [1:0]                resp,
  output logic                      m_en,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [NBYTE_W-1:0]        m_nbyte,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_busy,
  input  logic                      m_byte_req,
  input  logic                      m_rbyte_vld,
  input  logic [DATA_W-1:0]         m_rbyte,
  input  logic                      m_done,
  input  logic                      m_nack
);

  localparam int IW = $clog2(NREQ);

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [NBYTE_W-1:0]  nbyte_q, nbyte_d;
  logic                m_en_q, m_en_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0]     rvld_q, rvld_d;
  resp_e               resp_q, resp_d;

  logic [NREQ-1:0]     arb_oh;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_rw;
  logic [NBYTE_W-1:0]  w_nbyte;
  logic [DATA_W-1:0]   own_wdata;
  logic                byte_take;

  rr_arbiter_core #(
    .NREQ(NREQ)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt_oh(arb_oh),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    w_addr    = '0;
    w_rw      = 1'b0;
    w_nbyte   = '0;
    own_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_oh[i]) begin
        w_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_rw    = req_rw[i];
        w_nbyte = req_nbyte[i*NBYTE_W +: NBYTE_W];
      end
      if (gnt_q[i]) own_wdata = req_wdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);
  logic [15:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    nbyte_d = nbyte_q;
    m_en_d  = 1'b0;
    rdata_d = rdata_q;
    rvld_d  = '0;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (arb_any) begin
          state_d = LAUNCH;
          gnt_d   = arb_oh;
          idx_d   = arb_idx;
          addr_d  = w_addr;
          rw_d    = w_rw;
          nbyte_d = fix_nbyte(w_nbyte);
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        m_en_d  = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // a master that finishes before busy is seen still completes
        if (m_done) begin
          state_d = RESP;
          resp_d  = m_nack ? RESP_NACK : RESP_OK;
        end else if (m_busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (m_rbyte_vld) begin
          rdata_d = m_rbyte;
          rvld_d  = gnt_q;
        end
        if (m_done) begin
          state_d = RESP;
          resp_d  = m_nack ? RESP_NACK : RESP_OK;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    tmo_d = tmo_q;
    if (state_q == LAUNCH) begin
      tmo_d = '0;
    end else if (state_q == WAIT_BUSY || state_q == RUN) begin
      if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
      if (tmo_q >= TMO_LIM && !m_done) begin
        state_d = RESP;
        resp_d  = RESP_TIMEOUT;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      nbyte_q <= '0;
      m_en_q  <= 1'b0;
      rdata_q <= '0;
      rvld_q  <= '0;
      resp_q  <= RESP_OK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      nbyte_q <= nbyte_d;
      m_en_q  <= m_en_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      resp_q  <= resp_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  assign byte_take   = (state_q == RUN) && m_byte_req;
  assign wdata_ack   = byte_take ? gnt_q : '0;
  assign m_wdata     = byte_take ? own_wdata : '0;
  assign done        = (state_q == RESP) ? gnt_q : '0;
  assign gnt         = gnt_q;
  assign m_en        = m_en_q;
  assign m_rw        = rw_q;
  assign m_addr      = addr_q;
  assign m_nbyte     = nbyte_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
  assign resp        = resp_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: vector table plus
// hand sequences (drop in ARB, reset mid-run, contention).
module tb_i2c_master_arbiter;

  localparam int NREQ = 4;

  logic          clk;
  logic          resetN;
  logic [3:0]    req;
  logic [27:0]   req_addr;
  logic [3:0]    req_rw;
  logic [15:0]   req_nbyte;
  logic [31:0]   req_wdata;
  logic [3:0]    gnt;
  logic [3:0]    wdata_ack;
  logic [7:0]    rdata;
  logic [3:0]    rdata_valid;
  logic [3:0]    done;
  logic [1:0]    resp;
  logic          m_en;
  logic          m_rw;
  logic [6:0]    m_addr;
  logic [3:0]    m_nbyte;
  logic [7:0]    m_wdata;
  logic          m_busy;
  logic          m_byte_req;
  logic          m_rbyte_vld;
  logic [7:0]    m_rbyte;
  logic          m_done;
  logic          m_nack;

  int n_chk;
  int n_fail;

  i2c_master_arbiter #(
    .NREQ       (NREQ),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .req        (req),
    .req_addr   (req_addr),
    .req_rw     (req_rw),
    .req_nbyte  (req_nbyte),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .wdata_ack  (wdata_ack),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .done       (done),
    .resp       (resp),
    .m_en       (m_en),
    .m_rw       (m_rw),
    .m_addr     (m_addr),
    .m_nbyte    (m_nbyte),
    .m_wdata    (m_wdata),
    .m_busy     (m_busy),
    .m_byte_req (m_byte_req),
    .m_rbyte_vld(m_rbyte_vld),
    .m_rbyte    (m_rbyte),
    .m_done     (m_done),
    .m_nack     (m_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [6:0] addr;
    logic       rw;
    logic [3:0] nbyte;
    logic       nack;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         exp_nb;
    logic [1:0] exp_resp;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t vt[4];

  function automatic vec_t mkv(
    input int who, input logic [6:0] addr, input logic rw,
    input logic [3:0] nbyte, input logic nack,
    input logic [7:0] b0, input logic [7:0] b1,
    input logic [7:0] b2, input int exp_nb,
    input logic [1:0] exp_resp, input logic [3:0] exp_gnt
  );
    vec_t v;
    v.who = who; v.addr = addr; v.rw = rw;
    v.nbyte = nbyte; v.nack = nack;
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.exp_nb = exp_nb; v.exp_resp = exp_resp;
    v.exp_gnt = exp_gnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input vec_t v, input int k);
    return (k == 0) ? v.b0 : (k == 1) ? v.b1 : v.b2;
  endfunction

  // Runs one transaction from IDLE; v.who is the expected winner.
  task automatic txn(input vec_t v, input logic [3:0] reqv,
                     input bit keep);
    logic [7:0] b;
    req_addr[v.who*7 +: 7]  = v.addr;
    req_rw[v.who]           = v.rw;
    req_nbyte[v.who*4 +: 4] = v.nbyte;
    req_wdata[v.who*8 +: 8] = v.b0;
    req = reqv;
    tick();
    chk("arb_no_gnt", {gnt, m_en}, 0);
    tick();
    chk("gnt", gnt, v.exp_gnt);
    chk("gnt_onehot", $onehot(gnt), 1);
    chk("m_addr", m_addr, v.addr);
    chk("m_rw", m_rw, v.rw);
    chk("m_nbyte", m_nbyte, v.exp_nb);
    chk("m_en_early", m_en, 0);
    tick();
    chk("m_en_3rd_edge", m_en, 1);
    m_busy = 1'b1;
    tick();
    chk("m_en_1cyc", m_en, 0);
    for (int k = 0; k < v.exp_nb; k++) begin
      b = pick(v, k);
      if (!v.rw) begin
        m_byte_req = 1'b1;
        #1;
        chk("m_wdata", m_wdata, b);
        chk("wdata_ack", wdata_ack, v.exp_gnt);
        tick();
        m_byte_req = 1'b0;
        req_wdata[v.who*8 +: 8] = pick(v, k + 1);
      end else begin
        m_rbyte     = b;
        m_rbyte_vld = 1'b1;
        tick();
        m_rbyte_vld = 1'b0;
        chk("rdata_valid", rdata_valid, v.exp_gnt);
        chk("rdata", rdata, b);
      end
    end
    m_done = 1'b1;
    m_nack = v.nack;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
    m_busy = 1'b0;
    chk("done", done, v.exp_gnt);
    chk("resp", resp, v.exp_resp);
    chk("gnt_in_resp", gnt, v.exp_gnt);
    if (!keep) req = '0;
    tick();
    chk("done_1cyc", done, 0);
    chk("gnt_cleared", gnt, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetN = 1'b0;
    req = '0; req_addr = '0; req_rw = '0;
    req_nbyte = '0; req_wdata = '0;
    m_busy = 1'b0; m_byte_req = 1'b0; m_rbyte_vld = 1'b0;
    m_rbyte = '0; m_done = 1'b0; m_nack = 1'b0;

    vt[0] = mkv(0, 7'h50, 1'b0, 4'd2, 1'b0, 8'hA5, 8'h3C, 8'h00,
                2, 2'd0, 4'b0001);
    vt[1] = mkv(2, 7'h1D, 1'b1, 4'd3, 1'b0, 8'h11, 8'h22, 8'h33,
                3, 2'd0, 4'b0100);
    vt[2] = mkv(1, 7'h2A, 1'b0, 4'd0, 1'b1, 8'h5A, 8'h00, 8'h00,
                1, 2'd1, 4'b0010);
    vt[3] = mkv(3, 7'h7F, 1'b1, 4'd1, 1'b1, 8'hC3, 8'h00, 8'h00,
                1, 2'd1, 4'b1000);

    #1;
    chk("reset_ctl", {gnt, wdata_ack, rdata_valid, done, m_en, m_rw, resp}, 0);
    chk("reset_data", {m_addr, m_nbyte, rdata, m_wdata}, 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;

    for (int i = 0; i < 4; i++)
      txn(vt[i], vt[i].exp_gnt, 1'b0);

    // ptr is 0 again; NACK by 2 moves it to 3, then wrap to 0
    txn(mkv(2, 7'h33, 1'b0, 4'd1, 1'b1, 8'h77, 8'h00, 8'h00,
            1, 2'd1, 4'b0100), 4'b0100, 1'b0);
    txn(mkv(0, 7'h44, 1'b1, 4'd1, 1'b0, 8'h99, 8'h00, 8'h00,
            1, 2'd0, 4'b0001), 4'b0101, 1'b0);
    txn(mkv(2, 7'h45, 1'b0, 4'd1, 1'b0, 8'h66, 8'h00, 8'h00,
            1, 2'd0, 4'b0100), 4'b1100, 1'b0);

    // request withdrawn while in ARB: no grant, no launch
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    chk("drop_gnt", gnt, 0);
    tick();
    chk("drop_m_en", {m_en, gnt}, 0);

    // byte request outside RUN is ignored
    req_wdata = 32'hDEADBEEF;
    m_byte_req = 1'b1;
    #1;
    chk("idle_byte_req", {m_wdata, wdata_ack}, 0);
    m_byte_req = 1'b0;

    // asynchronous reset in the middle of a write byte
    req_addr[6:0] = 7'h12;
    req_nbyte[3:0] = 4'd4;
    req_rw[0] = 1'b0;
    req = 4'b0001;
    repeat (3) tick();
    m_busy = 1'b1;
    tick();
    m_byte_req = 1'b1;
    #1;
    chk("pre_reset_ack", wdata_ack, 4'b0001);
    resetN = 1'b0;
    #1;
    chk("rst_mid_ctl", {gnt, wdata_ack, rdata_valid, done, m_en, m_rw, resp}, 0);
    chk("rst_mid_data", {m_addr, m_nbyte, rdata, m_wdata}, 0);
    m_byte_req = 1'b0;
    m_busy = 1'b0;
    req = '0;
    tick();
    resetN = 1'b1;
    tick();
    chk("post_reset_idle", {gnt, done, m_en}, 0);

    // contention from ptr=0 with all requests held
    for (int r = 0; r < 5; r++) begin
      automatic int w = r % 4;
      txn(mkv(w, 7'(8'h20 + r), 1'b0, 4'd1, 1'b0, 8'(8'hB0 + r),
              8'h00, 8'h00, 1, 2'd0, 4'(1 << w)),
          4'b1111, r != 4);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      req_nbyte[3:0] = 4'd1;
      req = 4'b0001;
      repeat (3) tick();
      chk("tmo_m_en", m_en, 1);
      m_busy = 1'b1;
      while (n < 300 && done == 4'b0000) begin
        tick();
        n++;
      end
      chk("tmo_cycles", n, 101);
      chk("tmo_done", done, 4'b0001);
      chk("tmo_resp", resp, 2'd2);
      req = '0;
      m_busy = 1'b0;
      tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("tmo_late_done", {done, gnt}, 0);
      tick();
      chk("tmo_idle", {done, m_en}, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
